md4_round1_seq: RTL and testbench



---
 rtl/md4_round1_seq.sv | 163 ++++++++++++++++
 tb/tb_md4_round1_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/md4_round1_seq.sv
// -----------------------------------------------------------------------------
// md4_round1_seq
//
// Iterative MD4 round-1 engine. A single step datapath is reused for all
// sixteen round-1 steps, one step per clock, so a block takes 16 cycles in
// RUN instead of needing sixteen unrolled step instances.
//
// Ports:
//   clk                      system clock, all state on the rising edge
//   rst                      synchronous active-high reset
//   in_valid / in_ready      request handshake for a new block
//   a_in, b_in, c_in, d_in   32-bit chaining state
//   x_in                     512-bit message block, word k = x_in[32k+31:32k]
//   out_valid / out_ready    result handshake, consumer may backpressure
//   a_out .. d_out           round-1 result, zero whenever out_valid is low
//   busy                     high while the step datapath is iterating
// -----------------------------------------------------------------------------
module md4_round1_seq #(
   parameter int unsigned ROT0 = 3,
   parameter int unsigned ROT1 = 7,
   parameter int unsigned ROT2 = 11,
   parameter int unsigned ROT3 = 19
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  a_in,
   input  logic [31:0]  b_in,
   input  logic [31:0]  c_in,
   input  logic [31:0]  d_in,
   input  logic [511:0] x_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  a_out,
   output logic [31:0]  b_out,
   output logic [31:0]  c_out,
   output logic [31:0]  d_out,
   output logic         busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [4:0] ROT0_W = ROT0[4:0];
   localparam logic [4:0] ROT1_W = ROT1[4:0];
   localparam logic [4:0] ROT2_W = ROT2[4:0];
   localparam logic [4:0] ROT3_W = ROT3[4:0];

   logic [1:0]   state_q, state_d;
   logic [4:0]   step_q, step_d;
   logic [31:0]  a_q, a_d;
   logic [31:0]  b_q, b_d;
   logic [31:0]  c_q, c_d;
   logic [31:0]  d_q, d_d;
   logic [511:0] x_q, x_d;

   logic [31:0]  fVal;
   logic [31:0]  xWord;
   logic [31:0]  stepSum;
   logic [4:0]   rotAmt;
   logic [31:0]  newWord;

   // A zero rotate shifts right by 32, which yields zero and leaves v intact.
   function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
      return (v << s) | (v >> (6'd32 - {1'b0, s}));
   endfunction

   // Shared step datapath. F is the bitwise select "b ? c : d" on every bit,
   // and the sum wraps at 32 bits. The rotate amount cycles every four steps.
   always_comb begin
      fVal    = (b_q & c_q) | (~b_q & d_q);
      xWord   = x_q[{step_q[3:0], 5'd0} +: 32];
      stepSum = a_q + fVal + xWord;
      rotAmt  = ROT0_W;
      case (step_q[1:0])
         2'd0: rotAmt = ROT0_W;
         2'd1: rotAmt = ROT1_W;
         2'd2: rotAmt = ROT2_W;
         2'd3: rotAmt = ROT3_W;
         default: rotAmt = ROT0_W;
      endcase
      newWord = rotl32(stepSum, rotAmt);
   end

   // Next-state logic. The word register rotates (a,b,c,d) <= (d,new,b,c)
   // every RUN cycle so the same datapath always updates "a"; after sixteen
   // steps, a multiple of four, the original register order is back in place.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      x_d     = x_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               c_d     = c_in;
               d_d     = d_in;
               x_d     = x_in;
               step_d  = 5'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d    = d_q;
            b_d    = newWord;
            c_d    = b_q;
            d_d    = c_q;
            step_d = step_q + 5'd1;
            if (step_q == 5'd15) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any block in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         step_q  <= 5'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         c_q     <= 32'd0;
         d_q     <= 32'd0;
         x_q     <= 512'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         x_q     <= x_d;
      end
   end

   // Results are only exposed in DONE so the consumer never sees partial state.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      busy      = (state_q == S_RUN);
      out_valid = (state_q == S_DONE);
      a_out     = out_valid ? a_q : 32'd0;
      b_out     = out_valid ? b_q : 32'd0;
      c_out     = out_valid ? c_q : 32'd0;
      d_out     = out_valid ? d_q : 32'd0;
   end

endmodule

// File: tb/tb_md4_round1_seq.sv
// -----------------------------------------------------------------------------
// tb_md4_round1_seq
//
// Directed testbench for md4_round1_seq: reset state, latency, hand-computed
// round-1 vectors, backpressure, ignored mid-run requests, mid-run reset and
// back-to-back blocks checked against a reference MD4 round-1 function.
// -----------------------------------------------------------------------------
module tb_md4_round1_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  a_in, b_in, c_in, d_in;
   logic [511:0] x_in;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  a_out, b_out, c_out, d_out;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   md4_round1_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .d_in      (d_in),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_out     (a_out),
      .b_out     (b_out),
      .c_out     (c_out),
      .d_out     (d_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Advance one clock and settle away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference MD4 round 1 written in the textbook form: step i updates the
   // variable at position (-i mod 4) in place, using the next three as b,c,d.
   function automatic logic [127:0] goldenRound1(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] c, input logic [31:0] d,
                                                 input logic [511:0] x);
      logic [31:0] v [4];
      int          rots [4];
      logic [31:0] t;
      logic [31:0] vb, vc, vd;
      logic [63:0] dbl;
      int          idx;
      rots[0] = 3; rots[1] = 7; rots[2] = 11; rots[3] = 19;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 16; i++) begin
         idx = (4 - (i % 4)) % 4;
         vb  = v[(idx + 1) % 4];
         vc  = v[(idx + 2) % 4];
         vd  = v[(idx + 3) % 4];
         t   = v[idx] + ((vb & vc) | (~vb & vd)) + x[i*32 +: 32];
         dbl = {t, t};
         v[idx] = dbl[63 - rots[i % 4] -: 32];
      end
      return {v[0], v[1], v[2], v[3]};
   endfunction

   // Present a block and complete the input handshake; optionally keep
   // in_valid high afterwards for back-to-back operation.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input logic [31:0] d, input logic [511:0] x, input bit hold);
      int n;
      a_in = a; b_in = b; c_in = c; d_in = d; x_in = x;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      if (!in_ready) checkOutput("accept_timeout", {127'd0, in_ready}, 128'd1);
      tick();
      if (!hold) in_valid = 1'b0;
   endtask

   // Wait for out_valid after an acceptance, counting cycles and busy cycles.
   // When injectAt >= 0 a junk request is pulsed at that cycle of the run.
   task automatic waitDone(output int cycles, output int busyCnt, input int injectAt);
      cycles  = 0;
      busyCnt = 0;
      while (!out_valid && cycles < 40) begin
         if (busy) busyCnt++;
         if (injectAt >= 0 && cycles == injectAt) begin
            a_in = 32'hDEADBEEF; b_in = 32'h01234567; c_in = 32'h89ABCDEF; d_in = 32'h55AA55AA;
            x_in = {16{32'hA5A55A5A}};
            in_valid = 1'b1;
         end else if (injectAt >= 0 && cycles == injectAt + 1) begin
            in_valid = 1'b0;
         end
         tick();
         cycles++;
      end
      if (!out_valid) checkOutput("done_timeout", {127'd0, out_valid}, 128'd1);
   endtask

   logic [511:0] xOne;
   logic [127:0] expOne;
   logic [127:0] held;
   logic [127:0] expRand [3];
   logic [31:0]  ra [3], rb [3], rc [3], rd [3];
   logic [511:0] rx [3];
   int           acc [3];
   int           lat, busyCnt;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a_in = '0; b_in = '0; c_in = '0; d_in = '0; x_in = '0;
      xOne = '0;
      xOne[31:0] = 32'h00000001;
      expOne = {32'h00089800, 32'h40010045, 32'hC5408100, 32'h08888800};

      // Reset values
      tick(); tick();
      rst = 1'b0;
      checkOutput("reset_flags", {125'd0, in_ready, out_valid, busy}, {125'd0, 3'b100});
      checkOutput("reset_outs", {a_out, b_out, c_out, d_out}, 128'd0);

      // 1: all-zero block, exact 16-cycle latency
      applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 512'd0, 1'b0);
      waitDone(lat, busyCnt, -1);
      checkOutput("zero_latency", 128'(lat), 128'd16);
      checkOutput("zero_result", {a_out, b_out, c_out, d_out}, 128'd0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // 2: hand-computed vector with word0 = 1
      applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, xOne, 1'b0);
      waitDone(lat, busyCnt, -1);
      checkOutput("x1_result", {a_out, b_out, c_out, d_out}, expOne);
      checkOutput("x1_busy", 128'(busyCnt), 128'd16);

      // 3: backpressure holds outputs stable with in_ready low
      held = expOne;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("bp_outs", {a_out, b_out, c_out, d_out}, held);
         checkOutput("bp_flags", {126'd0, in_ready, out_valid}, {126'd0, 2'b01});
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checkOutput("bp_release", {126'd0, in_ready, out_valid}, {126'd0, 2'b10});

      // 4: request pulsed mid-run is ignored
      applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, xOne, 1'b0);
      waitDone(lat, busyCnt, 4);
      in_valid = 1'b0;
      checkOutput("ign_result", {a_out, b_out, c_out, d_out}, expOne);
      checkOutput("ign_busy", 128'(busyCnt), 128'd16);
      checkOutput("ign_latency", 128'(lat), 128'd16);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // 5: reset at step 8 aborts, then a new block completes
      applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, xOne, 1'b0);
      repeat (8) tick();
      checkOutput("abort_running", {127'd0, busy}, 128'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      checkOutput("abort_flags", {125'd0, in_ready, out_valid, busy}, {125'd0, 3'b100});
      checkOutput("abort_outs", {a_out, b_out, c_out, d_out}, 128'd0);
      applyStimulus(32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, {16{32'h0F1E2D3C}}, 1'b0);
      waitDone(lat, busyCnt, -1);
      checkOutput("abort_new_result", {a_out, b_out, c_out, d_out},
                  goldenRound1(32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, {16{32'h0F1E2D3C}}));
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // 6: back-to-back blocks with in_valid and out_ready held high
      for (int k = 0; k < 3; k++) begin
         ra[k] = $urandom; rb[k] = $urandom; rc[k] = $urandom; rd[k] = $urandom;
         for (int w = 0; w < 16; w++) rx[k][w*32 +: 32] = $urandom;
         expRand[k] = goldenRound1(ra[k], rb[k], rc[k], rd[k], rx[k]);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(ra[k], rb[k], rc[k], rd[k], rx[k], (k < 2));
         acc[k] = cyc;
         waitDone(lat, busyCnt, -1);
         checkOutput($sformatf("b2b_result%0d", k), {a_out, b_out, c_out, d_out}, expRand[k]);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      checkOutput("b2b_idle", {126'd0, in_ready, out_valid}, {126'd0, 2'b10});
      checkOutput("b2b_gap01", 128'(acc[1] - acc[0]), 128'd18);
      checkOutput("b2b_gap12", 128'(acc[2] - acc[1]), 128'd18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
